// File: rtl/csi2_video_gen_if.sv
// AXI4-Stream video channel between the CSI-2 test source and its consumers.
interface csi2_video_gen_if #(
  parameter int TDATA_WIDTH = 16
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/csi2_video_gen.sv
// Programmable AXI4-Stream frame source: tuser marks frame start, tlast marks line end.
//
// state         | meaning
// S_IDLE        | waiting for en_i, no output
// S_ACTIVE      | driving pixels of the current line
// S_LN_BLANK    | tvalid low between lines of a frame
// S_FRAME_BLANK | tvalid low after the final line, then restart or idle
module csi2_video_gen #(
  parameter int TDATA_WIDTH = 16,
  parameter int LN_BLANK    = 16,
  parameter int FRAME_BLANK = 64
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     en_i,
  input  logic [15:0]              px_per_ln_i,
  input  logic [15:0]              ln_per_frame_i,
  input  logic [1:0]               pattern_i,
  csi2_video_gen_if.master         video_o,
  output logic                     busy_o,
  output logic [31:0]              frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LN_BLANK, S_FRAME_BLANK} state_t;

  localparam logic [31:0] LN_BLANK_LD    = 32'(LN_BLANK > 0 ? LN_BLANK - 1 : 0);
  localparam logic [31:0] FRAME_BLANK_LD = 32'(FRAME_BLANK > 0 ? FRAME_BLANK - 1 : 0);

  state_t                 r_state;
  logic [15:0]            r_px;
  logic [15:0]            r_ln;
  logic [15:0]            r_px_last;
  logic [15:0]            r_ln_last;
  logic [1:0]             r_pat;
  logic [31:0]            r_blank_cnt;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic                   r_tuser;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic                   r_busy;
  logic [31:0]            r_frame_cnt;

  logic        w_fire;
  logic        w_start;
  logic        w_px_end;
  logic        w_ln_end;
  logic [15:0] w_px_nxt;
  logic [15:0] w_ln_nxt;
  logic [15:0] w_px_last_in;
  logic [15:0] w_ln_last_in;

  function automatic logic [TDATA_WIDTH-1:0] f_data(input logic [15:0] px,
                                                    input logic [15:0] ln,
                                                    input logic [1:0]  pat);
    logic [TDATA_WIDTH-1:0] v;
    v = '0;
    case (pat)
      2'd0:    v[15:0] = px;
      2'd1:    v[15:0] = ln;
      2'd2:    v[15:0] = px + ln;
      default: v = ln[0] ? '0 : '1;
    endcase
    return v;
  endfunction

  // Limits are stored as last-index so a zero request degenerates to one pixel/line.
  assign w_px_last_in = (px_per_ln_i == 16'd0)    ? 16'd0 : px_per_ln_i - 16'd1;
  assign w_ln_last_in = (ln_per_frame_i == 16'd0) ? 16'd0 : ln_per_frame_i - 16'd1;

  assign w_fire   = r_tvalid && video_o.tready;
  assign w_px_end = (r_px == r_px_last);
  assign w_ln_end = (r_ln == r_ln_last);
  assign w_px_nxt = r_px + 16'd1;
  assign w_ln_nxt = r_ln + 16'd1;
  assign w_start  = en_i && ((r_state == S_IDLE) ||
                             (r_state == S_FRAME_BLANK && r_blank_cnt == 32'd0));

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_state     <= S_IDLE;
      r_px        <= '0;
      r_ln        <= '0;
      r_px_last   <= '0;
      r_ln_last   <= '0;
      r_pat       <= '0;
      r_blank_cnt <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tdata     <= '0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
    end else if (w_start) begin
      r_px_last <= w_px_last_in;
      r_ln_last <= w_ln_last_in;
      r_pat     <= pattern_i;
      r_px      <= '0;
      r_ln      <= '0;
      r_tvalid  <= 1'b1;
      r_tdata   <= f_data(16'd0, 16'd0, pattern_i);
      r_tuser   <= 1'b1;
      r_tlast   <= (w_px_last_in == 16'd0);
      r_busy    <= 1'b1;
      r_state   <= S_ACTIVE;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (w_fire) begin
            r_tuser <= 1'b0;
            if (!w_px_end) begin
              r_px    <= w_px_nxt;
              r_tdata <= f_data(w_px_nxt, r_ln, r_pat);
              r_tlast <= (w_px_nxt == r_px_last);
            end else if (!w_ln_end) begin
              r_px <= '0;
              r_ln <= w_ln_nxt;
              if (LN_BLANK == 0) begin
                r_tdata <= f_data(16'd0, w_ln_nxt, r_pat);
                r_tlast <= (r_px_last == 16'd0);
              end else begin
                r_tvalid    <= 1'b0;
                r_tlast     <= 1'b0;
                r_blank_cnt <= LN_BLANK_LD;
                r_state     <= S_LN_BLANK;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 32'd1;
              r_tvalid    <= 1'b0;
              r_tlast     <= 1'b0;
              r_blank_cnt <= FRAME_BLANK_LD;
              r_state     <= S_FRAME_BLANK;
            end
          end
        end
        S_LN_BLANK: begin
          if (r_blank_cnt == 32'd0) begin
            r_tvalid <= 1'b1;
            r_tdata  <= f_data(r_px, r_ln, r_pat);
            r_tlast  <= (r_px_last == 16'd0);
            r_state  <= S_ACTIVE;
          end else begin
            r_blank_cnt <= r_blank_cnt - 32'd1;
          end
        end
        S_FRAME_BLANK: begin
          // Restart with en_i high is taken by w_start above.
          if (r_blank_cnt == 32'd0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_blank_cnt <= r_blank_cnt - 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign video_o.tvalid = r_tvalid;
  assign video_o.tdata  = r_tdata;
  assign video_o.tlast  = r_tlast;
  assign video_o.tuser  = r_tuser;
  assign busy_o         = r_busy;
  assign frame_cnt_o    = r_frame_cnt;

endmodule
